// File: rtl/vram_fetch_pkg.sv
// Shared types and default sizing for the VRAM scanline fetch block.
//   state_e         : fetch FSM states
//   *_DEF constants : default port-B address width, run-length width, FIFO depth
package vram_fetch_pkg;

    localparam int unsigned ADDR_W_DEF     = 15;
    localparam int unsigned LEN_W_DEF      = 12;
    localparam int unsigned FIFO_DEPTH_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FETCH  = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_FINISH = 2'd3
    } state_e;

endpackage

// File: rtl/vram_scanline_fetch_fifo.sv
// sync_fifo: single-clock first-word-fall-through FIFO with a registered head.
// The head register keeps its last value when the FIFO runs empty.
//   clk_i, rst_i     : clock, synchronous active-high reset
//   flush_i          : drop all entries (wins over push)
//   push_i/wr_data_i : write side; ignored while full unless a pop frees a slot
//   pop_i            : consume the head; ignored while empty
//   rd_data_o        : current head
//   full_o, empty_o  : occupancy flags (registered)
//   count_o          : number of stored entries
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wr_data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         rd_data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic             full_q, empty_q;
    logic             push_en_c, pop_en_c;

    // Next pointers, count and head value
    always_comb begin
        pop_en_c  = pop_i & ~empty_q;
        push_en_c = push_i & (~full_q | pop_en_c);
        wr_ptr_d  = wr_ptr_q + PTR_W'(push_en_c);
        rd_ptr_d  = rd_ptr_q + PTR_W'(pop_en_c);
        count_d   = count_q + CNT_W'(push_en_c) - CNT_W'(pop_en_c);
        head_d    = head_q;
        if (count_d != '0) begin
            // If nothing older survives this cycle, the incoming word becomes the head
            if (count_q == CNT_W'(pop_en_c)) begin
                head_d = wr_data_i;
            end else begin
                head_d = mem_q[rd_ptr_d];
            end
        end
    end

    // Storage array (no reset needed: contents are only read behind valid pointers)
    always_ff @(posedge clk_i) begin
        if (push_en_c && !flush_i) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

    // Control state
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            head_q   <= head_d;
            full_q   <= (count_d == CNT_W'(DEPTH));
            empty_q  <= (count_d == '0);
        end
    end

    assign rd_data_o = head_q;
    assign full_o    = full_q;
    assign empty_o   = empty_q;
    assign count_o   = count_q;

endmodule

// File: rtl/vram_scanline_fetch.sv
// vram_scanline_fetch: streams a run of consecutive bytes from RAM port B into a
// small FIFO and presents them as a valid/ready byte stream to the decoder.
//   clock, reset         : single clock, synchronous active-high reset
//   start/base_addr/length : begin a run (parameters sampled on start)
//   abort                : cancel the active run and flush buffered bytes
//   busy, done           : run in progress / one-cycle completion pulse
//   mem_addr, mem_rden   : RAM port B read request (registered)
//   mem_q                : RAM read data, valid one cycle after the request
//   out_data/out_valid/out_ready : byte stream to the decoder
module vram_scanline_fetch
    import vram_fetch_pkg::*;
#(
    parameter int unsigned ADDR_W     = ADDR_W_DEF,
    parameter int unsigned LEN_W      = LEN_W_DEF,
    parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [LEN_W-1:0]  length,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rden,
    input  logic [7:0]        mem_q,
    output logic [7:0]        out_data,
    output logic              out_valid,
    input  logic              out_ready
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned SUM_W = CNT_W + 1;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]  remaining_q, remaining_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              mem_rden_q, mem_rden_d;
    logic              pending_q;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic              fifo_push_c, fifo_pop_c, fifo_flush_c;
    logic              fifo_full, fifo_empty;
    logic [CNT_W-1:0]  fifo_count;
    logic [7:0]        fifo_data;
    logic              run_active_c, abort_c, room_c, drain_done_c;
    logic [SUM_W-1:0]  occupancy_c;

    // Run status, FIFO handshakes and issue headroom
    always_comb begin
        run_active_c = (state_q == ST_FETCH) || (state_q == ST_DRAIN);
        abort_c      = abort && run_active_c;
        fifo_pop_c   = out_ready && !fifo_empty;
        // Returning bytes are only kept while a run is live; after an abort they are dropped
        fifo_push_c  = pending_q && run_active_c && !abort;
        // Reserve a slot for every read already in flight so the FIFO cannot overflow
        occupancy_c  = SUM_W'(fifo_count) + SUM_W'(pending_q) + SUM_W'(mem_rden_q);
        room_c       = !fifo_full && (occupancy_c < SUM_W'(FIFO_DEPTH));
        // Run complete once nothing is in flight and the last byte leaves this cycle
        drain_done_c = !mem_rden_q && !pending_q &&
                       (fifo_empty || ((fifo_count == CNT_W'(1)) && fifo_pop_c));
    end

    // Next-state and output decode
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        remaining_d  = remaining_q;
        mem_addr_d   = mem_addr_q;
        mem_rden_d   = 1'b0;
        busy_d       = busy_q;
        done_d       = 1'b0;
        fifo_flush_c = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    busy_d = 1'b1;
                    if (length == '0) begin
                        state_d = ST_FINISH;
                    end else begin
                        // FIFO is empty and nothing is in flight here, so the first read goes out at once
                        mem_rden_d  = 1'b1;
                        mem_addr_d  = base_addr;
                        addr_d      = base_addr + ADDR_W'(1);
                        remaining_d = length - LEN_W'(1);
                        state_d     = (length == LEN_W'(1)) ? ST_DRAIN : ST_FETCH;
                    end
                end
            end

            ST_FETCH: begin
                if (abort) begin
                    fifo_flush_c = 1'b1;
                    state_d      = ST_FINISH;
                end else if (room_c) begin
                    mem_rden_d  = 1'b1;
                    mem_addr_d  = addr_q;
                    addr_d      = addr_q + ADDR_W'(1);
                    remaining_d = remaining_q - LEN_W'(1);
                    if (remaining_q == LEN_W'(1)) begin
                        state_d = ST_DRAIN;
                    end
                end
            end

            ST_DRAIN: begin
                if (abort) begin
                    fifo_flush_c = 1'b1;
                    state_d      = ST_FINISH;
                end else if (drain_done_c) begin
                    // Raise done together with the final pop
                    done_d  = 1'b1;
                    state_d = ST_FINISH;
                end
            end

            ST_FINISH: begin
                // Stay until done has been pulsed once (aborts and empty runs arrive without it)
                if (done_q) begin
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    done_d = 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            remaining_q <= '0;
            mem_addr_q  <= '0;
            mem_rden_q  <= 1'b0;
            pending_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
            mem_addr_q  <= mem_addr_d;
            mem_rden_q  <= mem_rden_d;
            // Data for last cycle's read is on mem_q this cycle
            pending_q   <= mem_rden_q;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i     (clock),
        .rst_i     (reset),
        .flush_i   (fifo_flush_c),
        .push_i    (fifo_push_c),
        .wr_data_i (mem_q),
        .pop_i     (fifo_pop_c),
        .rd_data_o (fifo_data),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty),
        .count_o   (fifo_count)
    );

    assign busy      = busy_q;
    assign done      = done_q;
    assign mem_addr  = mem_addr_q;
    assign mem_rden  = mem_rden_q;
    assign out_data  = fifo_data;
    assign out_valid = !fifo_empty;

endmodule

// File: tb/tb_vram_scanline_fetch.sv
// Directed bench for vram_scanline_fetch with a preloaded RAM model (mem[i] = i[7:0]).
module tb_vram_scanline_fetch;

    localparam int unsigned ADDR_W = 15;
    localparam int unsigned LEN_W  = 12;

    logic              clock;
    logic              reset;
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [LEN_W-1:0]  length;
    logic              abort;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rden;
    logic [7:0]        mem_q;
    logic [7:0]        out_data;
    logic              out_valid;
    logic              out_ready;

    logic [7:0]        ram [2**ADDR_W];

    int errors = 0;
    int checks = 0;

    int                rden_cnt = 0;
    int                done_cnt = 0;
    logic [7:0]        got[$];
    logic [ADDR_W-1:0] addr_log[$];

    vram_scanline_fetch dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .base_addr (base_addr),
        .length    (length),
        .abort     (abort),
        .busy      (busy),
        .done      (done),
        .mem_addr  (mem_addr),
        .mem_rden  (mem_rden),
        .mem_q     (mem_q),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // RAM port B read model: one-cycle latency
    always @(posedge clock) begin
        if (mem_rden) mem_q <= ram[mem_addr];
    end

    // Event recorder, sampled mid-cycle
    always @(negedge clock) begin
        if (!reset) begin
            if (mem_rden) begin
                rden_cnt = rden_cnt + 1;
                addr_log.push_back(mem_addr);
            end
            if (out_valid && out_ready) got.push_back(out_data);
            if (done) done_cnt = done_cnt + 1;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            errors = errors + 1;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_done(input int budget, input string tag);
        int n = 0;
        while (done !== 1'b1 && n < budget) begin
            cyc();
            n = n + 1;
        end
        check(tag, 32'(done), 32'd1);
    endtask

    task automatic pulse_start(input logic [ADDR_W-1:0] b, input logic [LEN_W-1:0] l);
        start     = 1'b1;
        base_addr = b;
        length    = l;
        cyc();
        start     = 1'b0;
    endtask

    int r0, g0, a0, d0;

    initial begin
        for (int i = 0; i < 2**ADDR_W; i++) ram[i] = 8'(i);
        reset     = 1'b1;
        start     = 1'b0;
        abort     = 1'b0;
        out_ready = 1'b1;
        base_addr = '0;
        length    = '0;

        // Reset values
        cyc();
        cyc();
        check("rst_busy",  32'(busy), 0);
        check("rst_done",  32'(done), 0);
        check("rst_addr",  32'(mem_addr), 0);
        check("rst_rden",  32'(mem_rden), 0);
        check("rst_valid", 32'(out_valid), 0);
        check("rst_data",  32'(out_data), 0);
        reset = 1'b0;
        cyc();
        cyc();

        // Basic run: base 0x10, length 4, consumer always ready
        r0 = rden_cnt; g0 = got.size(); d0 = done_cnt;
        pulse_start(15'h0010, 12'd4);                 // now cycle N+1
        check("t1_rden1", 32'(mem_rden), 1);
        check("t1_addr1", 32'(mem_addr), 32'h10);
        check("t1_busy1", 32'(busy), 1);
        cyc();                                        // N+2
        check("t1_valid_n2", 32'(out_valid), 0);
        for (int i = 0; i < 4; i++) begin
            cyc();                                    // N+3 .. N+6
            check("t1_valid", 32'(out_valid), 1);
            check("t1_data",  32'(out_data), 32'(8'h10 + 8'(i)));
        end
        cyc();                                        // N+7
        check("t1_done",       32'(done), 1);
        check("t1_valid_done", 32'(out_valid), 0);
        check("t1_busy_done",  32'(busy), 1);
        cyc();                                        // N+8
        check("t1_done_clr", 32'(done), 0);
        check("t1_busy_clr", 32'(busy), 0);
        cyc();
        check("t1_rden_cnt", 32'(rden_cnt - r0), 4);
        check("t1_bytes",    32'(got.size() - g0), 4);
        check("t1_done_cnt", 32'(done_cnt - d0), 1);

        // Backpressure: length 20, consumer stalled for 12 cycles
        r0 = rden_cnt; g0 = got.size();
        out_ready = 1'b0;
        pulse_start(15'h0010, 12'd20);                // N+1
        for (int i = 0; i < 11; i++) cyc();           // N+12
        check("t2_rden_stall", 32'(rden_cnt - r0), 8);
        check("t2_head_valid", 32'(out_valid), 1);
        check("t2_head_data",  32'(out_data), 32'h10);
        out_ready = 1'b1;
        wait_done(80, "t2_done_seen");
        cyc();
        cyc();
        check("t2_rden_total", 32'(rden_cnt - r0), 20);
        check("t2_bytes",      32'(got.size() - g0), 20);
        for (int i = 0; i < 20; i++) begin
            check("t2_data", 32'(got[g0 + i]), 32'(8'h10 + 8'(i)));
        end

        // Address wrap at the top of the address space
        a0 = addr_log.size(); g0 = got.size();
        pulse_start(15'h7FFE, 12'd4);
        wait_done(40, "t3_done_seen");
        cyc();
        cyc();
        check("t3_addr0", 32'(addr_log[a0 + 0]), 32'h7FFE);
        check("t3_addr1", 32'(addr_log[a0 + 1]), 32'h7FFF);
        check("t3_addr2", 32'(addr_log[a0 + 2]), 32'h0000);
        check("t3_addr3", 32'(addr_log[a0 + 3]), 32'h0001);
        check("t3_data0", 32'(got[g0 + 0]), 32'hFE);
        check("t3_data1", 32'(got[g0 + 1]), 32'hFF);
        check("t3_data2", 32'(got[g0 + 2]), 32'h00);
        check("t3_data3", 32'(got[g0 + 3]), 32'h01);

        // Zero-length run
        r0 = rden_cnt; d0 = done_cnt;
        pulse_start(15'h0100, 12'd0);                 // N+1
        check("t4_done_n1", 32'(done), 0);
        check("t4_busy_n1", 32'(busy), 1);
        cyc();                                        // N+2
        check("t4_done_n2",  32'(done), 1);
        check("t4_valid_n2", 32'(out_valid), 0);
        cyc();                                        // N+3
        check("t4_done_n3", 32'(done), 0);
        check("t4_busy_n3", 32'(busy), 0);
        check("t4_rden",    32'(rden_cnt - r0), 0);
        check("t4_done_cnt", 32'(done_cnt - d0), 1);
        cyc();

        // Abort three cycles into a length-16 run
        g0 = got.size(); d0 = done_cnt;
        pulse_start(15'h0030, 12'd16);                // N+1
        cyc();                                        // N+2
        cyc();                                        // N+3
        check("t5_valid_n3", 32'(out_valid), 1);
        check("t5_data_n3",  32'(out_data), 32'h30);
        abort = 1'b1;
        cyc();                                        // N+4
        abort = 1'b0;
        check("t5_valid_after", 32'(out_valid), 0);
        check("t5_rden_after",  32'(mem_rden), 0);
        cyc();                                        // N+5
        check("t5_done", 32'(done), 1);
        cyc();                                        // N+6
        check("t5_done_clr", 32'(done), 0);
        check("t5_busy_clr", 32'(busy), 0);
        for (int i = 0; i < 4; i++) cyc();
        check("t5_valid_idle", 32'(out_valid), 0);
        check("t5_bytes",      32'(got.size() - g0), 1);
        check("t5_byte0",      32'(got[g0]), 32'h30);
        check("t5_done_cnt",   32'(done_cnt - d0), 1);

        // Run after abort returns correct data
        g0 = got.size();
        pulse_start(15'h0060, 12'd3);
        wait_done(30, "t5b_done_seen");
        cyc();
        cyc();
        check("t5b_bytes", 32'(got.size() - g0), 3);
        for (int i = 0; i < 3; i++) begin
            check("t5b_data", 32'(got[g0 + i]), 32'(8'h60 + 8'(i)));
        end

        // Second start while busy is ignored, then reset mid-run
        pulse_start(15'h0120, 12'd10);                // N+1
        start     = 1'b1;                             // N+1 .. second start held through N+2
        base_addr = 15'h0200;
        length    = 12'd5;
        cyc();                                        // N+2
        cyc();                                        // N+3
        start     = 1'b0;
        check("t6_data_n3", 32'(out_data), 32'h20);
        cyc();                                        // N+4
        check("t6_data_n4", 32'(out_data), 32'h21);
        cyc();                                        // N+5
        check("t6_data_n5", 32'(out_data), 32'h22);
        check("t6_busy_n5", 32'(busy), 1);
        reset = 1'b1;
        cyc();
        check("t6_rst_busy",  32'(busy), 0);
        check("t6_rst_done",  32'(done), 0);
        check("t6_rst_addr",  32'(mem_addr), 0);
        check("t6_rst_rden",  32'(mem_rden), 0);
        check("t6_rst_valid", 32'(out_valid), 0);
        check("t6_rst_data",  32'(out_data), 0);
        cyc();
        reset = 1'b0;
        cyc();
        cyc();
        cyc();
        check("t6_post_valid", 32'(out_valid), 0);
        check("t6_post_busy",  32'(busy), 0);
        check("t6_post_rden",  32'(mem_rden), 0);

        // Fresh run after reset
        g0 = got.size();
        pulse_start(15'h0005, 12'd2);
        wait_done(30, "t7_done_seen");
        cyc();
        check("t7_bytes", 32'(got.size() - g0), 2);
        check("t7_data0", 32'(got[g0 + 0]), 32'h05);
        check("t7_data1", 32'(got[g0 + 1]), 32'h06);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/vram_scanline_fetch.md
Name: vram_scanline_fetch

Overview:
- Downstream read stage for the shared dual-port video/system RAM; drives its 8-bit byte port (port B).
- On a start pulse, streams a run of consecutive bytes from RAM into a small internal FIFO.
- Presents the FIFO as a valid/ready byte stream to the pixel/attribute decoder.
- Hides the RAM's 1-cycle read latency and absorbs decoder backpressure without dropping or duplicating bytes.

Parameters:
- ADDR_W, 15, byte address width of RAM port B.
- LEN_W, 12, width of the run-length field; the maximum run is 2^LEN_W-1 bytes.
- FIFO_DEPTH, 8, output FIFO entries; must be a power of 2 and at least 4.

Ports:
- clock  in  1  single clock; also drives RAM port B (clock_b).
- reset  in  1  synchronous, active-high.
- start  in  1  1-cycle pulse; begin a run.
- base_addr  in  ADDR_W  first byte address, sampled on start.
- length  in  LEN_W  number of bytes in the run, sampled on start.
- abort  in  1  cancel the run and flush the FIFO.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  1-cycle pulse when the last byte has been popped, or when a run is aborted.
- mem_addr  out  ADDR_W  to RAM address_b; registered.
- mem_rden  out  1  high in cycles where mem_addr is a valid issued read.
- mem_q  in  8  from RAM q_b; valid 1 cycle after the issuing cycle.
- out_data  out  8  head of the FIFO.
- out_valid  out  1  FIFO not empty.
- out_ready  in  1  consumer accepts out_data when out_valid & out_ready.

Behaviour:
- Reset values:
  - Outputs: busy=0, done=0, mem_addr=0, mem_rden=0, out_valid=0, out_data=0.
  - Internals: FIFO empty, state IDLE, pending=0.
- Reset wins over every other input, including in the middle of a run.
- State machine: IDLE, FETCH, DRAIN, FINISH.
  - IDLE: start=1 latches base_addr and length.
    - length=0: go to FINISH.
    - Otherwise: go to FETCH.
    - abort in IDLE has no effect.
  - FETCH: issue one read per cycle while (fifo_count + pending) < FIFO_DEPTH.
    - An issued read sets mem_rden=1 and mem_addr=current address.
    - After each issue: address+1, remaining-1.
    - When the last read issues, go to DRAIN.
  - DRAIN: wait until pending=0 and the FIFO is empty, then go to FINISH.
  - FINISH: done=1 for one cycle, busy=0 next cycle, return to IDLE.
- pending:
  - Set in any cycle with mem_rden=1.
  - In the following cycle, mem_q is written into the FIFO and pending clears, unless another read issued in that same cycle.
- Throughput:
  - One byte per cycle sustained when out_ready is held high.
  - First-byte latency: start at cycle N; mem_rden=1 with mem_addr=base at N+1; FIFO write at N+2; out_valid=1 at N+3.
- Address arithmetic: mem_addr increments modulo 2^ADDR_W; 2^ADDR_W-1 wraps to 0 with no error.
- start while busy=1 is ignored; latched parameters stay unchanged.
- abort while busy:
  - Next cycle: FIFO flushed, out_valid=0, mem_rden=0.
  - A byte returning from an outstanding read is discarded.
  - State goes to FINISH, so done pulses exactly once.
- Simultaneous abort and start in IDLE: start is taken.
- FIFO full: no read issues, so the FIFO can never overflow.
- FIFO empty with out_ready=1: nothing is popped; out_data holds its last value.
- Push and pop in the same cycle: fifo_count is unchanged.
- The block never writes RAM; the parent ties wren_b=0 and data_b=0.

Decomposition:
- Package vram_fetch_pkg holds:
  - a state enum typedef (IDLE/FETCH/DRAIN/FINISH);
  - the default ADDR_W, LEN_W and FIFO_DEPTH constants.
- Sub-module sync_fifo, parameterised by width and depth:
  - single clock, synchronous reset, plus a flush input;
  - ports push/pop/full/empty/count;
  - first-word-fall-through output.
- The top level keeps the FSM, address/length counters and pending logic.

Test Plan:
- RAM model preloaded with mem[i]=i[7:0]; base=0x0010, length=4, out_ready=1 -> out_data 10,11,12,13 on cycles N+3..N+6; done at N+7; exactly 4 mem_rden pulses.
- Same run with length=20 and out_ready low for the first 12 cycles -> mem_rden stops after 8 issues (FIFO full); all 20 bytes 0x10..0x23 delivered in order with no loss or duplicates.
- base=0x7FFE, length=4 -> mem_addr sequence 7FFE, 7FFF, 0000, 0001; data FE, FF, 00, 01.
- length=0 -> no mem_rden; done pulses 2 cycles after start; out_valid stays 0.
- Abort 3 cycles into a length=16 run -> out_valid=0 the next cycle; no bytes after abort; done pulses exactly once; a following start run returns correct data.
- start pulsed again while busy, then reset asserted mid-run -> second start ignored; after reset all outputs are at reset values and the FIFO is empty.
